// File: rtl/pipe_hazard_track_pkg.sv
// Shared types and constants for the E/M/W pipeline hazard tracker.
// Forwarding-select encoding, the zero-register index and a reference stage layout.
package pipe_hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF   = 2'b00,
        FWD_RESW = 2'b01,
        FWD_ALUM = 2'b10
    } fwd_sel_t;

    localparam int unsigned REG_ZERO   = 0;
    localparam int unsigned DEF_REG_W  = 5;
    localparam int unsigned DEF_CTRL_W = 8;

    typedef struct packed {
        logic                  valid;
        logic                  regwrite;
        logic                  memtoreg;
        logic [DEF_REG_W-1:0]  wreg;
        logic [DEF_CTRL_W-1:0] ctrl;
    } stage_t;

endpackage

// File: rtl/pipe_hazard_track_stage_reg.sv
// One pipeline stage register: valid bit plus a flat payload, with hold and bubble load.
// Any load with valid = 0 stores an all-zero payload so idle stages carry no stale fields.
module pipe_stage_reg
    import pipe_hazard_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         hold_i,
    input  logic         bubble_i,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q;
    logic         valid_d;
    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    // Next-state selection: hold, bubble/empty load, or normal load
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (hold_i) begin
            valid_d = valid_q;
            data_d  = data_q;
        end else if (bubble_i || !valid_i) begin
            valid_d = 1'b0;
            data_d  = '0;
        end else begin
            valid_d = 1'b1;
            data_d  = data_i;
        end
    end

    // State flops with synchronous reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_hazard_track.sv
// E/M/W control and destination tracking with stall, flush and forwarding generation.
// Hazard outputs are combinational from the stage registers and the D-stage inputs.
module pipe_hazard_track
    import pipe_hazard_pkg::*;
#(
    parameter int REG_W  = 5,
    parameter int CTRL_W = 8,
    parameter int NSRC   = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [CTRL_W-1:0]       in_ctrl,
    input  logic                    in_regwrite,
    input  logic                    in_memtoreg,
    input  logic [REG_W-1:0]        in_wreg,
    input  logic [NSRC*REG_W-1:0]   in_src,
    input  logic                    branch_d,
    input  logic                    mem_stall,
    output logic                    stall_f,
    output logic                    stall_d,
    output logic                    flush_e,
    output logic [NSRC*2-1:0]       fwd_e,
    output logic [NSRC-1:0]         fwd_d,
    output logic [CTRL_W-1:0]       ctrl_e,
    output logic [CTRL_W-1:0]       ctrl_m,
    output logic [CTRL_W-1:0]       ctrl_w,
    output logic                    regwrite_w,
    output logic                    memtoreg_w,
    output logic [REG_W-1:0]        wreg_w,
    output logic [2:0]              valid_emw
);

    localparam int MW = CTRL_W + 2 + REG_W;
    localparam int EW = MW + NSRC * REG_W;

    logic                  valid_e_s, valid_m_s, valid_w_s;
    logic [EW-1:0]         data_e_s;
    logic [MW-1:0]         data_m_s, data_w_s;
    logic [CTRL_W-1:0]     ctrl_e_s, ctrl_m_s, ctrl_w_s;
    logic                  rw_e_s, rw_m_s, rw_w_s;
    logic                  mtr_e_s, mtr_m_s, mtr_w_s;
    logic [REG_W-1:0]      wreg_e_s, wreg_m_s, wreg_w_s;
    logic [NSRC*REG_W-1:0] src_e_s;
    logic                  lu_s, br_s, hz_s;
    logic [NSRC*2-1:0]     fwd_e_s;
    logic [NSRC-1:0]       fwd_d_s;

    function automatic logic match(input logic v, input logic rw,
                                   input logic [REG_W-1:0] wr, input logic [REG_W-1:0] r);
        return v & rw & (wr == r) & (r != REG_W'(REG_ZERO));
    endfunction

    // Payload layout, MSB first: ctrl, regwrite, memtoreg, wreg, then sources (E only)
    assign ctrl_e_s = data_e_s[EW-1 -: CTRL_W];
    assign rw_e_s   = data_e_s[EW-1-CTRL_W];
    assign mtr_e_s  = data_e_s[EW-2-CTRL_W];
    assign wreg_e_s = data_e_s[NSRC*REG_W +: REG_W];
    assign src_e_s  = data_e_s[NSRC*REG_W-1:0];

    assign ctrl_m_s = data_m_s[MW-1 -: CTRL_W];
    assign rw_m_s   = data_m_s[REG_W+1];
    assign mtr_m_s  = data_m_s[REG_W];
    assign wreg_m_s = data_m_s[REG_W-1:0];

    assign ctrl_w_s = data_w_s[MW-1 -: CTRL_W];
    assign rw_w_s   = data_w_s[REG_W+1];
    assign mtr_w_s  = data_w_s[REG_W];
    assign wreg_w_s = data_w_s[REG_W-1:0];

    pipe_stage_reg #(.W(EW)) u_stage_e (
        .clk_i    (clk),
        .reset_i  (reset),
        .hold_i   (mem_stall),
        .bubble_i (hz_s),
        .valid_i  (in_valid),
        .data_i   ({in_ctrl, in_regwrite, in_memtoreg, in_wreg, in_src}),
        .valid_o  (valid_e_s),
        .data_o   (data_e_s)
    );

    pipe_stage_reg #(.W(MW)) u_stage_m (
        .clk_i    (clk),
        .reset_i  (reset),
        .hold_i   (mem_stall),
        .bubble_i (1'b0),
        .valid_i  (valid_e_s),
        .data_i   (data_e_s[EW-1 -: MW]),
        .valid_o  (valid_m_s),
        .data_o   (data_m_s)
    );

    pipe_stage_reg #(.W(MW)) u_stage_w (
        .clk_i    (clk),
        .reset_i  (reset),
        .hold_i   (mem_stall),
        .bubble_i (1'b0),
        .valid_i  (valid_m_s),
        .data_i   (data_m_s),
        .valid_o  (valid_w_s),
        .data_o   (data_w_s)
    );

    // Per-source hazard detection and forwarding selection
    always_comb begin
        lu_s    = 1'b0;
        br_s    = 1'b0;
        fwd_e_s = '0;
        fwd_d_s = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (match(valid_e_s, rw_e_s, wreg_e_s, in_src[k*REG_W +: REG_W]) && mtr_e_s && in_valid) begin
                lu_s = 1'b1;
            end else begin
                lu_s = lu_s;
            end
            if (branch_d && in_valid &&
                (match(valid_e_s, rw_e_s, wreg_e_s, in_src[k*REG_W +: REG_W]) ||
                 (match(valid_m_s, rw_m_s, wreg_m_s, in_src[k*REG_W +: REG_W]) && mtr_m_s))) begin
                br_s = 1'b1;
            end else begin
                br_s = br_s;
            end
            if (match(valid_m_s, rw_m_s, wreg_m_s, src_e_s[k*REG_W +: REG_W]) && !mtr_m_s) begin
                fwd_e_s[k*2 +: 2] = FWD_ALUM;
            end else if (match(valid_w_s, rw_w_s, wreg_w_s, src_e_s[k*REG_W +: REG_W])) begin
                fwd_e_s[k*2 +: 2] = FWD_RESW;
            end else begin
                fwd_e_s[k*2 +: 2] = FWD_RF;
            end
            if (match(valid_m_s, rw_m_s, wreg_m_s, in_src[k*REG_W +: REG_W]) && !mtr_m_s) begin
                fwd_d_s[k] = 1'b1;
            end else begin
                fwd_d_s[k] = 1'b0;
            end
        end
        hz_s = lu_s | br_s;
    end

    assign stall_f    = hz_s | mem_stall;
    assign stall_d    = hz_s | mem_stall;
    assign flush_e    = hz_s & ~mem_stall;
    assign fwd_e      = fwd_e_s;
    assign fwd_d      = fwd_d_s;
    assign ctrl_e     = valid_e_s ? ctrl_e_s : '0;
    assign ctrl_m     = valid_m_s ? ctrl_m_s : '0;
    assign ctrl_w     = valid_w_s ? ctrl_w_s : '0;
    assign regwrite_w = valid_w_s & rw_w_s;
    assign memtoreg_w = valid_w_s & mtr_w_s;
    assign wreg_w     = valid_w_s ? wreg_w_s : '0;
    assign valid_emw  = {valid_e_s, valid_m_s, valid_w_s};

endmodule

// File: tb/tb_pipe_hazard_track.sv
// Randomised and directed bench for pipe_hazard_track against an instruction-level pipeline model.
module tb_pipe_hazard_track;

    localparam int REG_W  = 5;
    localparam int CTRL_W = 8;
    localparam int NSRC   = 2;

    logic                  clk = 1'b0;
    logic                  reset, in_valid, in_regwrite, in_memtoreg, branch_d, mem_stall;
    logic [CTRL_W-1:0]     in_ctrl;
    logic [REG_W-1:0]      in_wreg;
    logic [NSRC*REG_W-1:0] in_src;
    logic                  stall_f, stall_d, flush_e, regwrite_w, memtoreg_w;
    logic [NSRC*2-1:0]     fwd_e;
    logic [NSRC-1:0]       fwd_d;
    logic [CTRL_W-1:0]     ctrl_e, ctrl_m, ctrl_w;
    logic [REG_W-1:0]      wreg_w;
    logic [2:0]            valid_emw;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic                  v;
        logic [CTRL_W-1:0]     ctrl;
        logic                  rw;
        logic                  mtr;
        logic [REG_W-1:0]      wreg;
        logic [NSRC*REG_W-1:0] src;
    } instr_t;

    instr_t st_e, st_m, st_w;

    pipe_hazard_track #(.REG_W(REG_W), .CTRL_W(CTRL_W), .NSRC(NSRC)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ctrl(in_ctrl),
        .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg), .in_wreg(in_wreg),
        .in_src(in_src), .branch_d(branch_d), .mem_stall(mem_stall),
        .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e), .fwd_e(fwd_e),
        .fwd_d(fwd_d), .ctrl_e(ctrl_e), .ctrl_m(ctrl_m), .ctrl_w(ctrl_w),
        .regwrite_w(regwrite_w), .memtoreg_w(memtoreg_w), .wreg_w(wreg_w),
        .valid_emw(valid_emw)
    );

    always #5 clk = ~clk;

    function automatic instr_t empty_instr();
        instr_t x;
        x.v = 1'b0; x.ctrl = '0; x.rw = 1'b0; x.mtr = 1'b0; x.wreg = '0; x.src = '0;
        return x;
    endfunction

    function automatic logic writes(input instr_t x, input logic [REG_W-1:0] r);
        return x.v && x.rw && (x.wreg == r) && (r != 0);
    endfunction

    function automatic logic [REG_W-1:0] dsrc(input int k);
        return in_src[k*REG_W +: REG_W];
    endfunction

    function automatic logic model_hz();
        logic h = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            if (in_valid && st_e.mtr && writes(st_e, dsrc(k))) h = 1'b1;
            if (in_valid && branch_d &&
                (writes(st_e, dsrc(k)) || (st_m.mtr && writes(st_m, dsrc(k))))) h = 1'b1;
        end
        return h;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        logic              hz;
        logic [NSRC*2-1:0] fe;
        logic [NSRC-1:0]   fd;
        hz = model_hz();
        fe = '0;
        fd = '0;
        for (int k = 0; k < NSRC; k++) begin
            logic [REG_W-1:0] r;
            r = st_e.src[k*REG_W +: REG_W];
            if (st_e.v && writes(st_m, r) && !st_m.mtr) fe[k*2 +: 2] = 2'd2;
            else if (st_e.v && writes(st_w, r))           fe[k*2 +: 2] = 2'd1;
            fd[k] = writes(st_m, dsrc(k)) && !st_m.mtr;
        end
        chk("stall_f", {31'd0, stall_f}, {31'd0, hz | mem_stall});
        chk("stall_d", {31'd0, stall_d}, {31'd0, hz | mem_stall});
        chk("flush_e", {31'd0, flush_e}, {31'd0, hz & ~mem_stall});
        chk("fwd_e", {28'd0, fwd_e}, {28'd0, fe});
        chk("fwd_d", {30'd0, fwd_d}, {30'd0, fd});
        chk("ctrl_e", {24'd0, ctrl_e}, {24'd0, st_e.v ? st_e.ctrl : 8'd0});
        chk("ctrl_m", {24'd0, ctrl_m}, {24'd0, st_m.v ? st_m.ctrl : 8'd0});
        chk("ctrl_w", {24'd0, ctrl_w}, {24'd0, st_w.v ? st_w.ctrl : 8'd0});
        chk("regwrite_w", {31'd0, regwrite_w}, {31'd0, st_w.v & st_w.rw});
        chk("memtoreg_w", {31'd0, memtoreg_w}, {31'd0, st_w.v & st_w.mtr});
        chk("wreg_w", {27'd0, wreg_w}, {27'd0, st_w.v ? st_w.wreg : 5'd0});
        chk("valid_emw", {29'd0, valid_emw}, {29'd0, st_e.v, st_m.v, st_w.v});
    endtask

    task automatic model_advance();
        instr_t d;
        logic   hz;
        hz = model_hz();
        d.v = in_valid; d.ctrl = in_ctrl; d.rw = in_regwrite; d.mtr = in_memtoreg;
        d.wreg = in_wreg; d.src = in_src;
        if (reset) begin
            st_e = empty_instr(); st_m = empty_instr(); st_w = empty_instr();
        end else if (!mem_stall) begin
            st_w = st_m;
            st_m = st_e;
            st_e = (hz || !in_valid) ? empty_instr() : d;
        end
    endtask

    task automatic drive(input logic rst, input logic v, input logic [CTRL_W-1:0] c,
                         input logic rw, input logic mtr, input logic [REG_W-1:0] wr,
                         input logic [REG_W-1:0] s0, input logic [REG_W-1:0] s1,
                         input logic br, input logic ms);
        @(negedge clk);
        reset = rst; in_valid = v; in_ctrl = c; in_regwrite = rw; in_memtoreg = mtr;
        in_wreg = wr; in_src = {s1, s0}; branch_d = br; mem_stall = ms;
        #1;
        compare_model();
    endtask

    task automatic tick();
        @(posedge clk);
        model_advance();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
            tick();
        end
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
    endtask

    initial begin
        st_e = empty_instr(); st_m = empty_instr(); st_w = empty_instr();
        reset = 1'b1; in_valid = 1'b0; in_ctrl = '0; in_regwrite = 1'b0; in_memtoreg = 1'b0;
        in_wreg = '0; in_src = '0; branch_d = 1'b0; mem_stall = 1'b0;
        @(posedge clk);
        @(posedge clk);
        do_reset();

        // Reset state
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("rst_valid", {29'd0, valid_emw}, 32'd0);
        chk("rst_stall", {31'd0, stall_f}, 32'd0);
        chk("rst_ctrl_w", {24'd0, ctrl_w}, 32'd0);
        tick();

        // Load-use: lw r8, then consumer of {r8, r3}
        drive(1'b0, 1'b1, 8'hA1, 1'b1, 1'b1, 5'd8, 5'd1, 5'd2, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b1, 8'hB2, 1'b1, 1'b0, 5'd9, 5'd8, 5'd3, 1'b0, 1'b0);
        chk("lu_stall", {29'd0, stall_f, stall_d, flush_e}, 32'd7);
        tick();
        drive(1'b0, 1'b1, 8'hB2, 1'b1, 1'b0, 5'd9, 5'd8, 5'd3, 1'b0, 1'b0);
        chk("lu_release", {31'd0, stall_f}, 32'd0);
        chk("lu_bubble", {29'd0, valid_emw}, 32'd2);
        tick();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("lu_fwd_resw", {30'd0, fwd_e[1:0]}, 32'd1);
        chk("lu_wreg_w", {27'd0, wreg_w}, 32'd8);
        tick();
        idle_cycles(3);

        // ALU back-to-back with the same register in M and W: M wins
        drive(1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b1, 8'h12, 1'b1, 1'b0, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b1, 8'h13, 1'b0, 1'b0, 5'd0, 5'd4, 5'd5, 1'b0, 1'b0);
        chk("alu_nostall", {31'd0, stall_f}, 32'd0);
        tick();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("alu_fwd_m_prio", {28'd0, fwd_e}, 32'h8);
        tick();
        idle_cycles(3);

        // Branch on a register produced by the ALU op in E
        drive(1'b0, 1'b1, 8'h21, 1'b1, 1'b0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 5'd0, 5'd7, 5'd0, 1'b1, 1'b0);
        chk("br_stall", {30'd0, stall_f, flush_e}, 32'd3);
        tick();
        drive(1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 5'd0, 5'd7, 5'd0, 1'b1, 1'b0);
        chk("br_fwd_d", {30'd0, fwd_d}, 32'd1);
        chk("br_release", {31'd0, stall_f}, 32'd0);
        tick();
        idle_cycles(3);

        // mem_stall for 3 cycles over a load-use hazard, then one bubble
        drive(1'b0, 1'b1, 8'h31, 1'b1, 1'b1, 5'd8, 5'd0, 5'd0, 1'b0, 1'b0); tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 8'h32, 1'b1, 1'b0, 5'd9, 5'd8, 5'd0, 1'b0, 1'b1);
            chk("ms_flush", {30'd0, stall_f, flush_e}, 32'd2);
            chk("ms_valid", {29'd0, valid_emw}, 32'd4);
            chk("ms_ctrl_e", {24'd0, ctrl_e}, 32'h31);
            tick();
        end
        drive(1'b0, 1'b1, 8'h32, 1'b1, 1'b0, 5'd9, 5'd8, 5'd0, 1'b0, 1'b0);
        chk("ms_release_flush", {31'd0, flush_e}, 32'd1);
        tick();
        drive(1'b0, 1'b1, 8'h32, 1'b1, 1'b0, 5'd9, 5'd8, 5'd0, 1'b0, 1'b0);
        chk("ms_one_bubble", {29'd0, valid_emw}, 32'd2);
        chk("ms_no_second", {31'd0, flush_e}, 32'd0);
        tick();
        idle_cycles(3);

        // Writes to r0 never stall or forward
        drive(1'b0, 1'b1, 8'h41, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b1, 8'h42, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        chk("r0_nostall", {31'd0, stall_f}, 32'd0);
        tick();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("r0_fwd", {26'd0, fwd_e, fwd_d}, 32'd0);
        tick();

        // Reset asserted while a load-use stall is pending
        drive(1'b0, 1'b1, 8'h51, 1'b1, 1'b1, 5'd6, 5'd0, 5'd0, 1'b0, 1'b0); tick();
        drive(1'b1, 1'b1, 8'h52, 1'b1, 1'b0, 5'd9, 5'd6, 5'd0, 1'b0, 1'b0);
        chk("rst_mid_stall_pre", {31'd0, stall_f}, 32'd1);
        tick();
        drive(1'b0, 1'b1, 8'h52, 1'b1, 1'b0, 5'd9, 5'd6, 5'd0, 1'b0, 1'b0);
        chk("rst_mid_valid", {29'd0, valid_emw}, 32'd0);
        chk("rst_mid_stall", {31'd0, stall_f}, 32'd0);
        tick();

        // Randomised traffic over a small register pool to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 80) ? 1'b1 : 1'b0,
                  8'($urandom),
                  1'($urandom),
                  1'($urandom),
                  5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)),
                  ($urandom_range(0, 99) < 25) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 15) ? 1'b1 : 1'b0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
